// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry registered N:1 output channel.
// The grant doubles as the accept strobe; a per-requester lock holds ownership for a burst.
module mux_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ-1:0]       i_lock,
  input  logic [NREQ*WIDTH-1:0] i_in_data,
  output logic [NREQ-1:0]       o_grant,
  output logic [SELW-1:0]       o_sel,
  output logic [WIDTH-1:0]      o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_locked
);

  typedef enum logic {StArb, StLocked} state_e;

  state_e            r_state, w_state_d;
  logic [SELW-1:0]   r_sel, w_sel_d;
  logic [SELW-1:0]   r_ptr, w_ptr_d;
  logic [WIDTH-1:0]  r_out_data, w_out_data_d;
  logic              r_out_valid, w_out_valid_d;

  logic              w_cap;
  logic              w_found;
  logic              w_acc;
  logic [SELW-1:0]   w_win;
  logic [WIDTH-1:0]  w_win_data;
  int unsigned       w_idx;

  assign w_cap = !r_out_valid || i_out_ready;

  // Winner: rotating search from ptr+1 in ARB, the current owner in LOCKED.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_sel;
    w_idx   = 0;
    if (r_state == StLocked) begin
      w_found = i_req[r_sel];
    end else begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        w_idx = (int'(r_ptr) + k) % NREQ;
        if (!w_found && i_req[w_idx]) begin
          w_found = 1'b1;
          w_win   = SELW'(w_idx);
        end
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == SELW'(i)) w_win_data = i_in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_acc   = w_cap && w_found && !i_reset;
  assign o_grant = w_acc ? (NREQ'(1) << w_win) : '0;

  always_comb begin
    w_state_d     = r_state;
    w_sel_d       = r_sel;
    w_ptr_d       = r_ptr;
    w_out_data_d  = r_out_data;
    w_out_valid_d = r_out_valid;

    if (w_acc) begin
      w_out_data_d  = w_win_data;
      w_out_valid_d = 1'b1;
      w_sel_d       = w_win;
      w_ptr_d       = w_win;
    end else if (r_out_valid && i_out_ready) begin
      w_out_valid_d = 1'b0;
    end

    unique case (r_state)
      StArb: begin
        if (w_acc && i_lock[w_win]) w_state_d = StLocked;
      end
      StLocked: begin
        // Owner withdrew its request: abandon the burst without a grant.
        if (w_cap && !i_req[r_sel]) w_state_d = StArb;
        else if (w_acc && !i_lock[r_sel]) w_state_d = StArb;
      end
      default: w_state_d = StArb;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StArb;
      r_sel       <= SELW'(NREQ - 1);
      r_ptr       <= SELW'(NREQ - 1);
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_sel       <= w_sel_d;
      r_ptr       <= w_ptr_d;
      r_out_data  <= w_out_data_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign o_sel       = r_sel;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_locked    = (r_state == StLocked);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: rotation, wrap, backpressure, lock bursts and mid-run reset.
module tb_mux_rr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SELW  = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       grant;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  locked;

  int n_assert;
  int n_fail;

  mux_rr_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_lock      (lock),
    .i_in_data   (in_data),
    .o_grant     (grant),
    .o_sel       (sel),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = 4'b1111;
    lock      = 4'b0000;
    out_ready = 1'b1;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_sel", 32'(sel), 32'd3);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_grant", 32'(grant), 32'h0);

    tick();
    rst = 1'b0;
    #1;
    // Full rotation starting after ptr=3.
    for (int k = 0; k < 4; k++) begin
      chk("rot_grant", 32'(grant), 32'(4'b0001 << k));
      tick();
      chk("rot_data", 32'(out_data), 32'hA0 + 32'(k));
      chk("rot_valid", 32'(out_valid), 32'd1);
      chk("rot_sel", 32'(sel), 32'(k));
      #1;
    end

    // Wrap-around between 3 and 0.
    req = 4'b1001;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_grant", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h8);
      tick();
      chk("wrap_data", 32'(out_data), (k % 2 == 0) ? 32'hA0 : 32'hA3);
      chk("wrap_valid", 32'(out_valid), 32'd1);
      #1;
    end

    // Backpressure stall.
    out_ready = 1'b0;
    req       = 4'b0010;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_grant", 32'(grant), 32'h0);
      tick();
      chk("stall_data", 32'(out_data), 32'hA3);
      chk("stall_valid", 32'(out_valid), 32'd1);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_grant", 32'(grant), 32'h2);
    tick();
    chk("unstall_data", 32'(out_data), 32'hA1);
    chk("unstall_sel", 32'(sel), 32'd1);

    // Drain with no new request.
    req = 4'b0000;
    #1;
    chk("drain_grant", 32'(grant), 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data), 32'hA1);

    // Lock burst on requester 2 while requester 0 waits.
    req  = 4'b0101;
    lock = 4'b0100;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("burst_grant", 32'(grant), 32'h4);
      tick();
      chk("burst_locked", 32'(locked), 32'd1);
      chk("burst_data", 32'(out_data), 32'hA2);
      #1;
    end
    lock = 4'b0000;
    #1;
    chk("burst_last_grant", 32'(grant), 32'h4);
    tick();
    chk("burst_end_locked", 32'(locked), 32'd0);
    chk("burst_end_sel", 32'(sel), 32'd2);
    #1;
    chk("post_burst_grant", 32'(grant), 32'h1);
    tick();
    chk("post_burst_data", 32'(out_data), 32'hA0);
    chk("post_burst_sel", 32'(sel), 32'd0);

    // Abandoned lock on requester 1.
    req  = 4'b1010;
    lock = 4'b0010;
    #1;
    chk("abn_grant1", 32'(grant), 32'h2);
    tick();
    chk("abn_locked", 32'(locked), 32'd1);
    chk("abn_sel", 32'(sel), 32'd1);
    req = 4'b1000;
    #1;
    chk("abn_idle_grant", 32'(grant), 32'h0);
    tick();
    chk("abn_unlocked", 32'(locked), 32'd0);
    chk("abn_sel_hold", 32'(sel), 32'd1);
    chk("abn_valid", 32'(out_valid), 32'd0);
    #1;
    chk("abn_grant3", 32'(grant), 32'h8);
    tick();
    chk("abn_data3", 32'(out_data), 32'hA3);
    chk("abn_sel3", 32'(sel), 32'd3);

    // Reset while holding a locked, unconsumed word.
    req  = 4'b0010;
    lock = 4'b0010;
    #1;
    chk("pre_rst_grant", 32'(grant), 32'h2);
    tick();
    out_ready = 1'b0;
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd3);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    rst       = 1'b0;
    req       = 4'b1010;
    lock      = 4'b0000;
    out_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(grant), 32'h2);
    tick();
    chk("post_rst_data", 32'(out_data), 32'hA1);
    chk("post_rst_locked", 32'(locked), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit output channel (a registered N:1 multiplexer) between NREQ requesters.
- Each cycle it picks at most one requesting source and captures that source's data into a one-entry output register. The grant doubles as the requester's accept strobe.
- An optional lock lets one requester hold the channel for a multi-word burst.
- Sits between producer blocks and a single downstream consumer that applies backpressure through out_ready.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, data word width.
- SELW, 2, width of the sel output; must be at least ceil(log2(NREQ)).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  request vector; bit i is held high while requester i has a valid word.
- lock  input  NREQ  lock vector; bit i asks to keep ownership after the current grant.
- in_data  input  NREQ*WIDTH  flattened data; word i occupies bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot accept strobe; combinational from state and inputs.
- sel  output  SELW  index of the current or last owner (registered).
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word this cycle.
- locked  output  1  FSM is in the LOCKED state.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, sel=NREQ-1, ptr=NREQ-1, state=ARB, locked=0. grant is all zeros while reset is asserted.
- Capture enable: cap = !out_valid || out_ready. No grant is issued when cap=0.
- Selection in state ARB:
  - Search req starting at index ptr+1 and wrapping modulo NREQ; the first set bit is the winner w.
  - If req is all zeros, there is no winner: grant=0 and ptr is unchanged.
- Selection in state LOCKED: the winner is w=sel, and only if req[sel]=1.
- Accept: when cap && winner exists, grant[w]=1. At the next edge:
  - out_data<=in_data[w], out_valid<=1;
  - sel<=w, ptr<=w.
- Drain: when out_valid && out_ready && no accept, out_valid<=0 at the next edge and out_data holds its value.
- Simultaneous drain and accept: out_valid stays 1 and out_data takes the new word. Throughput is 1 word per cycle with zero-bubble back-to-back transfers.
- Grant rules:
  - grant is never asserted to a requester whose req is low.
  - grant is at most one-hot.
  - A requester must keep req and its in_data stable until it sees grant. Dropping req before grant is permitted (the request is withdrawn).
- FSM:
  - ARB -> LOCKED on an accept where lock[w]=1.
  - LOCKED -> LOCKED on an accept where lock[sel]=1.
  - LOCKED -> ARB on an accept where lock[sel]=0. This is the last word of the burst; ptr advances so the next search starts at sel+1.
  - LOCKED -> ARB when req[sel]=0 and cap=1. This abandons the burst with no grant that cycle.
  - In LOCKED with cap=0 (stalled): hold state, no change.
  - locked=1 exactly while state=LOCKED.
- Fairness: in ARB, every requester with req held high is granted within NREQ accepts. A lock extends this bound by the burst length.
- Completeness: every output and next-state value is assigned on every path, in both the combinational and sequential processes. No storage is inferred other than the flops listed here: out_data, out_valid, sel, ptr, state.
- Reset mid-operation: an in-flight word is discarded (out_valid->0 immediately) and any lock is released. There is no grant while reset is high.
- sel and ptr never exceed NREQ-1, and wrap-around from NREQ-1 goes to 0.

Test Plan:
- Reset then req=4'b1111 with out_ready=1 held:
  - grants are 0,1,2,3,0 in consecutive cycles;
  - out_data follows in_data words 0xA0..0xA3, one cycle after each grant;
  - out_valid=1 continuously from the first capture.
- req=4'b1001 after the last grant to 3 (ptr=3) -> grant[0] first, then grant[3], alternating. The wrap-around from 3 to 0 is exercised.
- out_ready=0 with out_valid=1 and req=4'b0010:
  - grant stays 0 and out_data holds for 5 cycles;
  - when out_ready rises, grant[1] and the new word are captured in the same cycle.
- Lock burst: req[2]=1 with lock[2]=1 for 3 accepts, then lock[2]=0 on the 4th, while req[0] is held throughout:
  - grants 2,2,2,2 with locked=1 after the first accept, then grant 0;
  - locked returns to 0 after the 4th word.
- Abandoned lock: in LOCKED on sel=1, req[1] drops while req[3]=1 -> one idle cycle with locked going to 0, then grant[3].
- Assert reset while out_valid=1 and locked=1 -> out_valid=0, locked=0, sel=3 immediately; the first post-reset grant goes to the lowest requesting index.
